// File: rtl/demux432b_buf.sv
// 1-to-4 write-side demultiplexer: routes a word by select into one of four
// single-entry holding registers, each with its own valid/ready and delivery counter.
module demux432b_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic [4*CNT_W-1:0]   xfer_cnt
);

    logic [WIDTH-1:0] data_p0 [4];
    logic [3:0]       vld_p0;
    logic [CNT_W-1:0] cnt_p0  [4];
    logic             wr;
    logic [3:0]       drain;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + CNT_W'(1);
    endfunction

    // A full channel still accepts when its consumer drains it this same cycle.
    assign in_ready = rst_n & (~vld_p0[in_sel] | out_ready[in_sel]);
    assign wr       = in_valid & in_ready;
    assign drain    = vld_p0 & out_ready;

    // Holding-register stage: input side to out_* side, one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= '0;
            for (int k = 0; k < 4; k++) begin
                data_p0[k] <= '0;
                cnt_p0[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wr && (in_sel == 2'(k))) begin
                    data_p0[k] <= in_data;
                    vld_p0[k]  <= 1'b1;
                end else if (drain[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
                if (drain[k])
                    cnt_p0[k] <= cnt_inc(cnt_p0[k]);
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_data0 = data_p0[0];
    assign out_data1 = data_p0[1];
    assign out_data2 = data_p0[2];
    assign out_data3 = data_p0[3];

    always_comb begin
        xfer_cnt = '0;
        for (int k = 0; k < 4; k++)
            xfer_cnt[k*CNT_W +: CNT_W] = cnt_p0[k];
    end

endmodule
